// File: rtl/pre_if_stage_pkg.sv
// Shared widths, packet layout and FSM encoding for the pre-IF fetch front end.
package pre_if_stage_pkg;

  localparam int PFS_TO_FS_BUS_WD  = 81;
  localparam int BR_BUS_WD         = 33;
  localparam int EXCP_NUM_ADEF_BIT = 14;
  localparam logic [15:0] EXCP_NUM_ADEF = 16'h0001 << EXCP_NUM_ADEF_BIT;

  typedef enum logic [1:0] {
    S_REQ,
    S_DATA,
    S_HOLD,
    S_ADEF
  } pfs_state_t;

  // Field order matches the bus bit layout, LSB field last.
  typedef struct packed {
    logic [15:0] excp_num;
    logic        excp;
    logic [31:0] inst;
    logic [31:0] pc;
  } pfs_to_fs_t;

  // A misaligned fetch address never reaches the bus; it becomes an ADEF packet.
  function automatic pfs_state_t fetch_entry(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) ? S_ADEF : S_REQ;
  endfunction

endpackage

// File: rtl/pre_if_stage_redirect_sel.sv
// Redirect priority mux: exception entry beats ertn return beats branch target.
module fetch_redirect_sel
  import pre_if_stage_pkg::*;
(
  input  logic                 excp_flush,
  input  logic                 ertn_flush,
  input  logic [BR_BUS_WD-1:0] br_bus,
  input  logic [31:0]          eentry,
  input  logic [31:0]          era,
  output logic                 redir,
  output logic [31:0]          target
);

  logic br_taken;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    target   = br_bus[31:0];
    // An unknown br_taken from an idle ID/EX stage must not look like a branch.
    br_taken = (br_bus[32] === 1'b1);
    redir    = excp_flush | ertn_flush | br_taken;
    if (excp_flush) begin
      target = eentry;
    end else if (ertn_flush) begin
      target = era;
    end
  end

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, issues one outstanding sram-like fetch at a
// time, discards responses made stale by a redirect, and hands packets to IF.
module pre_if_stage
  import pre_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fs_allowin,
  output logic                        pfs_to_fs_valid,
  output logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
  input  logic [BR_BUS_WD-1:0]        br_bus,
  input  logic                        excp_flush,
  input  logic                        ertn_flush,
  input  logic [31:0]                 eentry,
  input  logic [31:0]                 era,
  output logic                        inst_sram_req,
  output logic                        inst_sram_wr,
  output logic [1:0]                  inst_sram_size,
  output logic [3:0]                  inst_sram_wstrb,
  output logic [31:0]                 inst_sram_addr,
  output logic [31:0]                 inst_sram_wdata,
  input  logic                        inst_sram_addr_ok,
  input  logic                        inst_sram_data_ok,
  input  logic [31:0]                 inst_sram_rdata
);

  pfs_state_t  state;
  logic [31:0] pc;
  logic [31:0] pc_seq;
  logic        cancel;
  logic        adef_sent;
  pfs_to_fs_t  buf_pkt;
  pfs_to_fs_t  adef_pkt;
  logic        redir;
  logic [31:0] target;
  logic        handoff;

  fetch_redirect_sel u_redirect_sel (
    .excp_flush (excp_flush),
    .ertn_flush (ertn_flush),
    .br_bus     (br_bus),
    .eentry     (eentry),
    .era        (era),
    .redir      (redir),
    .target     (target)
  );

  assign pc_seq   = pc + 32'd4;
  assign adef_pkt = '{excp_num: EXCP_NUM_ADEF, excp: 1'b1, inst: 32'h0, pc: pc};

  // A redirect in the same cycle suppresses the packet, so it also blocks the handoff.
  assign pfs_to_fs_valid = ~reset & ~redir &
                           ((state == S_HOLD) | ((state == S_ADEF) & ~adef_sent));
  assign handoff         = pfs_to_fs_valid & fs_allowin;
  assign pfs_to_fs_bus   = (state == S_ADEF) ? adef_pkt : buf_pkt;

  // HOLD issues the next sequential fetch in the handoff cycle for back-to-back fetch.
  assign inst_sram_req   = ~reset & ((state == S_REQ) | ((state == S_HOLD) & handoff));
  assign inst_sram_addr  = (state == S_HOLD) ? pc_seq : pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      cancel    <= 1'b0;
      adef_sent <= 1'b0;
      // NOTE: the packet buffer is a single register, reset so the bus reads zero out of reset.
      buf_pkt   <= '0;
    end else begin
      if (redir) begin
        pc <= target;
      end
      case (state)
        S_REQ: begin
          if (inst_sram_addr_ok) begin
            state  <= S_DATA;
            cancel <= redir;
          end else if (redir) begin
            state <= fetch_entry(target);
          end
        end
        S_DATA: begin
          if (inst_sram_data_ok) begin
            cancel <= 1'b0;
            if (cancel | redir) begin
              state <= fetch_entry(redir ? target : pc);
            end else begin
              buf_pkt <= '{excp_num: 16'h0, excp: 1'b0, inst: inst_sram_rdata, pc: pc};
              state   <= S_HOLD;
            end
          end else if (redir) begin
            cancel <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redir) begin
            state <= fetch_entry(target);
          end else if (handoff) begin
            pc    <= pc_seq;
            state <= inst_sram_addr_ok ? S_DATA : S_REQ;
          end
        end
        S_ADEF: begin
          if (redir) begin
            state     <= fetch_entry(target);
            adef_sent <= 1'b0;
          end else if (handoff) begin
            adef_sent <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_data_ok_only_in_data: assert property (
    @(posedge clk) disable iff (reset) inst_sram_data_ok |-> (state == S_DATA)
  );
`endif

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed, table-driven bench for pre_if_stage: one table row per clock cycle.
module tb_pre_if_stage;
  import pre_if_stage_pkg::*;

  localparam logic [31:0] RST    = 32'h1c000000;
  localparam logic [31:0] EENTRY = 32'h1c008000;
  localparam logic [31:0] ERA    = 32'h1c00c000;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        fs_allowin = 1'b0;
  logic                        pfs_to_fs_valid;
  logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus;
  logic [BR_BUS_WD-1:0]        br_bus = '0;
  logic                        excp_flush = 1'b0;
  logic                        ertn_flush = 1'b0;
  logic [31:0]                 eentry = EENTRY;
  logic [31:0]                 era = ERA;
  logic                        inst_sram_req;
  logic                        inst_sram_wr;
  logic [1:0]                  inst_sram_size;
  logic [3:0]                  inst_sram_wstrb;
  logic [31:0]                 inst_sram_addr;
  logic [31:0]                 inst_sram_wdata;
  logic                        inst_sram_addr_ok = 1'b0;
  logic                        inst_sram_data_ok = 1'b0;
  logic [31:0]                 inst_sram_rdata = '0;

  pre_if_stage #(.RESET_PC(RST)) dut (
    .clk               (clk),
    .reset             (reset),
    .fs_allowin        (fs_allowin),
    .pfs_to_fs_valid   (pfs_to_fs_valid),
    .pfs_to_fs_bus     (pfs_to_fs_bus),
    .br_bus            (br_bus),
    .excp_flush        (excp_flush),
    .ertn_flush        (ertn_flush),
    .eentry            (eentry),
    .era               (era),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        allowin;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] br_tgt;
    logic        ex;
    logic        er;
    logic        req_chk;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input string nm, input logic aw, input logic ao, input logic dk,
                     input logic [31:0] rd, input logic br, input logic [31:0] bt,
                     input logic ex, input logic er, input logic rc, input logic rq,
                     input logic [31:0] ad, input logic vl, input logic [31:0] p,
                     input logic [31:0] i, input logic xc);
    vec_t v;
    v.name = nm;   v.allowin = aw; v.addr_ok = ao; v.data_ok = dk; v.rdata = rd;
    v.br = br;     v.br_tgt = bt;  v.ex = ex;      v.er = er;
    v.req_chk = rc; v.req = rq;    v.addr = ad;    v.valid = vl;
    v.pc = p;      v.inst = i;     v.excp = xc;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [80:0] act, input logic [80:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    logic [80:0] exp_bus;

    // name         aw ao dk rdata          br bt            ex er  rc rq addr        vl pc           inst           xc
    add("t1_req0",   1, 0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, RST,        0, 32'h0,        32'h0,         0);
    add("t1_req1",   1, 1, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, RST,        0, 32'h0,        32'h0,         0);
    add("t1_data",   1, 0, 1, 32'h02800000,  0, 32'h0,         0, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t1_hold",   1, 0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, RST+4,      1, RST,          32'h02800000,  0);
    add("t1_req2",   1, 1, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, RST+4,      0, 32'h0,        32'h0,         0);
    add("t1_data2",  1, 0, 1, 32'h11111111,  0, 32'h0,         0, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t1_hold2",  1, 0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, RST+8,      1, RST+4,        32'h11111111,  0);
    for (int k = 0; k < 3; k++)
      add("t2_wait", 1, 0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, RST+8,      0, 32'h0,        32'h0,         0);
    add("t2_acc",    1, 1, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, RST+8,      0, 32'h0,        32'h0,         0);
    add("t3_br",     1, 0, 0, 32'h0,         1, 32'h1c000100,  0, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t3_drop",   1, 0, 1, 32'hdeadbeef,  0, 32'h0,         0, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t3_req",    1, 1, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, 32'h1c000100, 0, 32'h0,      32'h0,         0);
    add("t3_data",   1, 0, 1, 32'h22222222,  0, 32'h0,         0, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    for (int k = 0; k < 5; k++)
      add("t5_stall", 0, 0, 0, 32'h0,        0, 32'h0,         0, 0,  1, 0, 32'h0,      1, 32'h1c000100, 32'h22222222,  0);
    add("t5_go",     1, 1, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, 32'h1c000104, 1, 32'h1c000100, 32'h22222222, 0);
    add("t5_data",   1, 0, 1, 32'h33333333,  0, 32'h0,         0, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t4_flush",  1, 0, 0, 32'h0,         1, 32'h1c000200,  1, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t4_req",    1, 1, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, EENTRY,     0, 32'h0,        32'h0,         0);
    add("t4_data",   1, 0, 1, 32'h44444444,  0, 32'h0,         0, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t6_hold",   1, 0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, EENTRY+4,   1, EENTRY,       32'h44444444,  0);
    add("t6_ertn",   1, 0, 0, 32'h0,         1, 32'h1c000900,  0, 1,  0, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t6_req",    1, 1, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, ERA,        0, 32'h0,        32'h0,         0);
    add("t6_data",   1, 0, 1, 32'h55555555,  0, 32'h0,         0, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t7_b2b",    1, 1, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, ERA+4,      1, ERA,          32'h55555555,  0);
    add("t7_brdok",  1, 0, 1, 32'h66666666,  1, 32'h1c000300,  0, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t7_req",    1, 1, 0, 32'h0,         1, 32'h1c000400,  0, 0,  1, 1, 32'h1c000300, 0, 32'h0,      32'h0,         0);
    add("t7_rebr",   1, 0, 0, 32'h0,         1, 32'h1c000102,  0, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t7_drop",   1, 0, 1, 32'h77777777,  0, 32'h0,         0, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t8_adef",   0, 0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 0, 32'h0,      1, 32'h1c000102, 32'h0,         1);
    add("t8_hand",   1, 0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 0, 32'h0,      1, 32'h1c000102, 32'h0,         1);
    for (int k = 0; k < 2; k++)
      add("t8_wait", 1, 0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t8_redir",  1, 0, 0, 32'h0,         1, 32'h1c000500,  0, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t8_req",    1, 1, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, 32'h1c000500, 0, 32'h0,      32'h0,         0);
    add("t8_data",   1, 0, 1, 32'h88888888,  0, 32'h0,         0, 0,  1, 0, 32'h0,      0, 32'h0,        32'h0,         0);
    add("t8_hold",   1, 0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, 32'h1c000504, 1, 32'h1c000500, 32'h88888888, 0);
    add("t8_next",   1, 0, 0, 32'h0,         0, 32'h0,         0, 0,  1, 1, 32'h1c000504, 0, 32'h0,      32'h0,         0);

    // Reset held across several edges: outputs must sit at their reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",   81'(inst_sram_req),   81'(1'b0));
    check("rst_valid", 81'(pfs_to_fs_valid), 81'(1'b0));
    check("rst_bus",   81'(pfs_to_fs_bus),   81'(0));
    check("const_wr",    81'(inst_sram_wr),    81'(1'b0));
    check("const_size",  81'(inst_sram_size),  81'(2'b10));
    check("const_wstrb", 81'(inst_sram_wstrb), 81'(4'h0));
    check("const_wdata", 81'(inst_sram_wdata), 81'(32'h0));

    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk);
      #1;
      reset             = 1'b0;
      fs_allowin        = vecs[k].allowin;
      inst_sram_addr_ok = vecs[k].addr_ok;
      inst_sram_data_ok = vecs[k].data_ok;
      inst_sram_rdata   = vecs[k].rdata;
      br_bus            = {vecs[k].br, vecs[k].br_tgt};
      excp_flush        = vecs[k].ex;
      ertn_flush        = vecs[k].er;
      @(negedge clk);
      check($sformatf("%s[%0d].valid", vecs[k].name, k), 81'(pfs_to_fs_valid), 81'(vecs[k].valid));
      if (vecs[k].req_chk) begin
        check($sformatf("%s[%0d].req", vecs[k].name, k), 81'(inst_sram_req), 81'(vecs[k].req));
        if (vecs[k].req)
          check($sformatf("%s[%0d].addr", vecs[k].name, k), 81'(inst_sram_addr), 81'(vecs[k].addr));
      end
      if (vecs[k].valid) begin
        exp_bus = {(vecs[k].excp ? 16'h4000 : 16'h0000), vecs[k].excp, vecs[k].inst, vecs[k].pc};
        check($sformatf("%s[%0d].bus", vecs[k].name, k), pfs_to_fs_bus, exp_bus);
      end
    end

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
